// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions used by the fetch stage and its bench.
//   NOP_INSTR    : canonical bubble instruction (addi x0,x0,0)
//   RESET_VECTOR : default PC after reset
//   ifid_t       : contents of the IF/ID pipeline register
package riscv_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h00000013;
  localparam logic [31:0] RESET_VECTOR = 32'h00000000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } ifid_t;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: hazard/redirect controls, instruction-memory port
// and IF/ID outputs.
//   master : the fetch stage (drives imem_ra_o, ifid_*, misalign_o, fetch_cnt_o)
//   slave  : the surrounding pipeline / memory (drives controls and imem_rd_i)
interface if_stage_if #(
  parameter int INS_ADDRESS = 9,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 32
);
  logic                   stall_i;
  logic                   flush_i;
  logic                   redirect_i;
  logic [DATA_W-1:0]      redirect_target_i;
  logic [INS_ADDRESS-1:0] imem_ra_o;
  logic [DATA_W-1:0]      imem_rd_i;
  logic [DATA_W-1:0]      ifid_pc_o;
  logic [DATA_W-1:0]      ifid_pc4_o;
  logic [DATA_W-1:0]      ifid_instr_o;
  logic                   ifid_valid_o;
  logic                   misalign_o;
  logic [CNT_W-1:0]       fetch_cnt_o;

  modport master (
    input  stall_i, flush_i, redirect_i, redirect_target_i, imem_rd_i,
    output imem_ra_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o,
           misalign_o, fetch_cnt_o
  );

  modport slave (
    output stall_i, flush_i, redirect_i, redirect_target_i, imem_rd_i,
    input  imem_ra_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o,
           misalign_o, fetch_cnt_o
  );
endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection for the fetch stage.
//   pc        in  current PC
//   stall     in  hold PC
//   redirect  in  load target (overrides stall)
//   target    in  redirect target, low two bits forced to zero
//   pc_plus4  out pc + 4 (wraps)
//   pc_next   out PC for the next cycle
//   misalign  out redirect target was not word aligned
module pc_next_sel #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] pc,
  input  logic              stall,
  input  logic              redirect,
  input  logic [DATA_W-1:0] target,
  output logic [DATA_W-1:0] pc_plus4,
  output logic [DATA_W-1:0] pc_next,
  output logic              misalign
);

  assign pc_plus4 = pc + DATA_W'(4);

  // Flush does not appear here: a flushed cycle still advances the PC.
  always_comb begin
    pc_next  = pc_plus4;
    misalign = 1'b0;
    if (redirect) begin
      pc_next  = {target[DATA_W-1:2], 2'b00};
      misalign = |target[1:0];
    end else if (stall) begin
      pc_next = pc;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, instruction-memory address, IF/ID
// register and delivered-fetch counter.
//   clk    in  clock, all state on posedge
//   reset  in  synchronous active-high reset
//   bus    master side of if_stage_if (controls, imem port, IF/ID outputs)
module if_stage
  import riscv_pkg::*;
#(
  parameter int                INS_ADDRESS = 9,
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] RESET_PC    = RESET_VECTOR,
  parameter int                CNT_W       = 32
) (
  input  logic       clk,
  input  logic       reset,
  if_stage_if.master bus
);

  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] pc_next;
  logic              misalign_next;
  logic              misalign_q;
  logic [CNT_W-1:0]  fetch_cnt_q;
  ifid_t             ifid_q;

  pc_next_sel #(.DATA_W(DATA_W)) u_pc_next_sel (
    .pc       (pc_q),
    .stall    (bus.stall_i),
    .redirect (bus.redirect_i),
    .target   (bus.redirect_target_i),
    .pc_plus4 (pc_plus4),
    .pc_next  (pc_next),
    .misalign (misalign_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      ifid_q      <= '{pc: '0, pc4: '0, instr: NOP_INSTR, valid: 1'b0};
      misalign_q  <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      pc_q       <= pc_next;
      misalign_q <= misalign_next;
      // Bubbles keep the previous pc/pc4 fields; only instr and valid change.
      if (bus.redirect_i || (!bus.stall_i && bus.flush_i)) begin
        ifid_q.instr <= NOP_INSTR;
        ifid_q.valid <= 1'b0;
      end else if (!bus.stall_i) begin
        ifid_q      <= '{pc: pc_q, pc4: pc_plus4, instr: bus.imem_rd_i, valid: 1'b1};
        fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
      end
    end
  end

  // Addresses above the memory size alias by truncation.
  assign bus.imem_ra_o    = pc_q[INS_ADDRESS-1:0];
  assign bus.ifid_pc_o    = ifid_q.pc;
  assign bus.ifid_pc4_o   = ifid_q.pc4;
  assign bus.ifid_instr_o = ifid_q.instr;
  assign bus.ifid_valid_o = ifid_q.valid;
  assign bus.misalign_o   = misalign_q;
  assign bus.fetch_cnt_o  = fetch_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_stage_if bus ();

  if_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference state, tracked as plain values
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_cnt;
  logic        m_valid, m_mis;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] idx;
    idx = (addr % 32'd512) / 32'd4;
    return 32'h00100093 + (idx << 20);
  endfunction

  assign bus.imem_rd_i = mem_word({23'b0, bus.imem_ra_o});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the reference by the fetch rules.
  task automatic tick(input logic r, input logic s, input logic f, input logic rd,
                      input logic [31:0] t);
    reset                 = r;
    bus.stall_i           = s;
    bus.flush_i           = f;
    bus.redirect_i        = rd;
    bus.redirect_target_i = t;
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = 32'h00000013;
      m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
    end else if (rd) begin
      m_pc    = t & 32'hFFFF_FFFC;
      m_instr = 32'h00000013;
      m_valid = 1'b0;
      m_mis   = (t % 4) != 0;
    end else begin
      m_mis = 1'b0;
      if (!s) begin
        if (f) begin
          m_instr = 32'h00000013;
          m_valid = 1'b0;
        end else begin
          m_ipc   = m_pc;
          m_ipc4  = m_pc + 32'd4;
          m_instr = mem_word(m_pc);
          m_valid = 1'b1;
          m_cnt   = m_cnt + 32'd1;
        end
        m_pc = m_pc + 32'd4;
      end
    end
    chk_en = 1'b1;
    #2;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_ra",    {23'b0, bus.imem_ra_o}, m_pc % 32'd512);
      check("ifid_pc",    bus.ifid_pc_o,          m_ipc);
      check("ifid_pc4",   bus.ifid_pc4_o,         m_ipc4);
      check("ifid_instr", bus.ifid_instr_o,       m_instr);
      check("ifid_valid", {31'b0, bus.ifid_valid_o}, {31'b0, m_valid});
      check("misalign",   {31'b0, bus.misalign_o},   {31'b0, m_mis});
      check("fetch_cnt",  bus.fetch_cnt_o,        m_cnt);
    end
  end

  initial begin
    // Reset held three cycles
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 32'h0);
    check("rst_imem_ra",   {23'b0, bus.imem_ra_o}, 32'h0);
    check("rst_valid",     {31'b0, bus.ifid_valid_o}, 32'h0);
    check("rst_instr",     bus.ifid_instr_o, 32'h00000013);
    check("rst_fetch_cnt", bus.fetch_cnt_o, 32'h0);

    // Release: first word delivered one cycle later
    tick(0, 0, 0, 0, 32'h0);
    check("rel_ifid_pc", bus.ifid_pc_o, 32'h0);
    check("rel_valid",   {31'b0, bus.ifid_valid_o}, 32'h1);
    check("rel_imem_ra", {23'b0, bus.imem_ra_o}, 32'h4);

    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 32'h0);
    check("free_ifid_pc",  bus.ifid_pc_o, 32'd16);
    check("free_instr",    bus.ifid_instr_o, 32'h00500093);
    check("free_pc4",      bus.ifid_pc4_o, 32'd20);
    check("free_fetch_cnt", bus.fetch_cnt_o, 32'd5);

    // Stall with pc=8
    tick(1, 0, 0, 0, 32'h0);
    tick(0, 0, 0, 0, 32'h0);
    tick(0, 0, 0, 0, 32'h0);
    tick(0, 1, 0, 0, 32'h0);
    tick(0, 1, 1, 0, 32'h0);   // flush ignored under stall
    check("stall_imem_ra", {23'b0, bus.imem_ra_o}, 32'd8);
    check("stall_ifid_pc", bus.ifid_pc_o, 32'd4);
    check("stall_valid",   {31'b0, bus.ifid_valid_o}, 32'h1);
    check("stall_cnt",     bus.fetch_cnt_o, 32'd2);
    tick(0, 0, 0, 0, 32'h0);
    check("unstall_ifid_pc", bus.ifid_pc_o, 32'd8);

    // Flush alone: bubble, pc advances
    tick(0, 0, 1, 0, 32'h0);
    check("flush_valid",   {31'b0, bus.ifid_valid_o}, 32'h0);
    check("flush_imem_ra", {23'b0, bus.imem_ra_o}, 32'd16);
    check("flush_ifid_pc", bus.ifid_pc_o, 32'd8);

    // Redirect beats stall and flush
    tick(0, 1, 1, 1, 32'h54);
    check("redir_imem_ra", {23'b0, bus.imem_ra_o}, 32'h54);
    check("redir_valid",   {31'b0, bus.ifid_valid_o}, 32'h0);
    check("redir_instr",   bus.ifid_instr_o, 32'h00000013);
    tick(0, 0, 0, 0, 32'h0);
    check("redir_ifid_pc", bus.ifid_pc_o, 32'h54);
    check("redir_instr2",  bus.ifid_instr_o, 32'h01600093);

    // Misaligned target
    tick(0, 0, 0, 1, 32'h66);
    check("mis_imem_ra", {23'b0, bus.imem_ra_o}, 32'h64);
    check("mis_pulse",   {31'b0, bus.misalign_o}, 32'h1);
    tick(0, 0, 0, 0, 32'h0);
    check("mis_clear",   {31'b0, bus.misalign_o}, 32'h0);
    check("mis_ifid_pc", bus.ifid_pc_o, 32'h64);

    // Back-to-back redirects
    tick(0, 0, 0, 1, 32'h100);
    tick(0, 0, 0, 1, 32'h20);
    check("b2b_imem_ra", {23'b0, bus.imem_ra_o}, 32'h20);
    tick(0, 0, 0, 0, 32'h0);
    tick(0, 0, 0, 0, 32'h0);

    // Address aliasing past the memory size, then mid-run reset
    tick(0, 0, 0, 1, 32'h1FC);
    tick(0, 0, 0, 0, 32'h0);
    check("alias_imem_ra", {23'b0, bus.imem_ra_o}, 32'h0);
    check("alias_ifid_pc", bus.ifid_pc_o, 32'h1FC);
    check("alias_instr",   bus.ifid_instr_o, 32'h08000093);
    tick(0, 0, 0, 0, 32'h0);
    tick(1, 0, 0, 0, 32'h0);
    check("midrst_imem_ra", {23'b0, bus.imem_ra_o}, 32'h0);
    check("midrst_valid",   {31'b0, bus.ifid_valid_o}, 32'h0);
    check("midrst_cnt",     bus.fetch_cnt_o, 32'h0);

    // 32-bit PC wrap
    tick(0, 0, 0, 0, 32'h0);
    tick(0, 0, 0, 1, 32'hFFFF_FFFC);
    tick(0, 0, 0, 0, 32'h0);
    check("wrap_ifid_pc4", bus.ifid_pc4_o, 32'h0);
    check("wrap_imem_ra",  {23'b0, bus.imem_ra_o}, 32'h0);
    tick(0, 0, 0, 0, 32'h0);

    @(posedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
